// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one single-ported memory between an instruction-fetch port and a
//   data port. Each access runs IDLE -> ACCESS (MEM_LAT cycles) -> RESP
//   (one-cycle ack) -> IDLE. The data port has fixed priority over fetch.
//
// Optional feature (compile-time macro MEM_ARB_STARVE_GUARD_EN):
//   When defined, a saturating counter tracks fetch losses. When it reaches
//   STARVE_LIMIT, fetch wins the next arbitration even if data is requesting.
//   When undefined, priority is strictly data over fetch.
//
// Parameters:
//   ADDR_W        address width
//   DATA_W        data width
//   MEM_LAT       memory access cycles, 1..15
//   STARVE_LIMIT  fetch losses before a forced fetch grant, 1..15
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   if_req, if_addr                    fetch request and address (read only)
//   if_rdata, if_ack                   fetch read data and completion pulse
//   dm_req, dm_we, dm_addr, dm_wdata   data request, direction, address, data
//   dm_rdata, dm_ack                   data read data and completion pulse
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata               memory port
//   busy                               high whenever the FSM is not in IDLE
//   grant_id                           owner of current access, 0=fetch 1=data
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  // Elaboration-time guard on the legal parameter ranges.
  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT out of range 1..15");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
    $error("mem_arbiter: STARVE_LIMIT out of range 1..15");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              gid_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic              any_req;
  logic              pick_fetch;
  logic              arb_fire;
  logic              last_access;

  assign any_req     = if_req | dm_req;
  assign arb_fire    = (state == IDLE) & any_req;
  assign last_access = (state == ACCESS) & (cnt == 4'd0);

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_q;
  logic       starved;

  assign starved    = (starve_q == 4'(STARVE_LIMIT));
  // A starved fetch overrides data priority; otherwise fetch only wins alone.
  assign pick_fetch = if_req & (~dm_req | starved);

  // Counts arbitrations fetch lost; saturates so the override stays armed
  // until fetch actually gets the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 4'd0;
    end else if (arb_fire) begin
      if (pick_fetch) begin
        starve_q <= 4'd0;
      end else if (if_req && !starved) begin
        starve_q <= starve_q + 4'd1;
      end
    end
  end
`else
  assign pick_fetch = ~dm_req;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are latched at arbitration so requester-side changes during the
  // access never reach the memory port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      gid_q   <= 1'b0;
    end else if (arb_fire) begin
      cnt     <= 4'(MEM_LAT - 1);
      gid_q   <= ~pick_fetch;
      addr_q  <= pick_fetch ? if_addr : dm_addr;
      we_q    <= pick_fetch ? 1'b0 : dm_we;
      wdata_q <= pick_fetch ? '0 : dm_wdata;
    end else if ((state == ACCESS) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Read data is captured on the final access cycle, into the winner's
  // register only; writes leave both registers untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else if (last_access && !we_q) begin
      if (gid_q) begin
        dm_rdata_q <= mem_rdata;
      end else begin
        if_rdata_q <= mem_rdata;
      end
    end
  end

  // Outputs decoded from registered state; the memory port reads as zero
  // outside ACCESS.
  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign if_ack    = (state == RESP) & ~gid_q;
  assign dm_ack    = (state == RESP) & gid_q;
  assign busy      = (state != IDLE);
  assign grant_id  = gid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;

  // DUT A: MEM_LAT=2, STARVE_LIMIT=4
  logic          a_if_req;
  logic [AW-1:0] a_if_addr;
  logic [DW-1:0] a_if_rdata;
  logic          a_if_ack;
  logic          a_dm_req;
  logic          a_dm_we;
  logic [AW-1:0] a_dm_addr;
  logic [DW-1:0] a_dm_wdata;
  logic [DW-1:0] a_dm_rdata;
  logic          a_dm_ack;
  logic          a_mem_en;
  logic          a_mem_we;
  logic [AW-1:0] a_mem_addr;
  logic [DW-1:0] a_mem_wdata;
  logic [DW-1:0] a_mem_rdata;
  logic          a_busy;
  logic          a_grant_id;

  // DUT B: MEM_LAT=1
  logic          b_if_req;
  logic [AW-1:0] b_if_addr;
  logic [DW-1:0] b_if_rdata;
  logic          b_if_ack;
  logic          b_dm_req;
  logic          b_dm_we;
  logic [AW-1:0] b_dm_addr;
  logic [DW-1:0] b_dm_wdata;
  logic [DW-1:0] b_dm_rdata;
  logic          b_dm_ack;
  logic          b_mem_en;
  logic          b_mem_we;
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] b_mem_wdata;
  logic [DW-1:0] b_mem_rdata;
  logic          b_busy;
  logic          b_grant_id;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2), .STARVE_LIMIT(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .dm_rdata(a_dm_rdata), .dm_ack(a_dm_ack),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .busy(a_busy), .grant_id(a_grant_id)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_LIMIT(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_ack(b_dm_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .busy(b_busy), .grant_id(b_grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both acks of DUT A must never be high together.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert (!(a_if_ack && a_dm_ack)) else begin
        errors++;
        $error("FAIL ack_excl: observed both acks high expected at most one");
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    a_if_req = 1'b0; a_if_addr = '0; a_dm_req = 1'b0; a_dm_we = 1'b0;
    a_dm_addr = '0; a_dm_wdata = '0; a_mem_rdata = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_dm_req = 1'b0; b_dm_we = 1'b0;
    b_dm_addr = '0; b_dm_wdata = '0; b_mem_rdata = '0;

    // Reset state
    #2;
    check("rst_mem_en", a_mem_en, 0);
    check("rst_busy", a_busy, 0);
    check("rst_grant", a_grant_id, 0);
    check("rst_if_rdata", a_if_rdata, 0);
    check("rst_dm_rdata", a_dm_rdata, 0);
    check("rst_acks", {a_if_ack, a_dm_ack}, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Fetch-only read, MEM_LAT=2
    a_if_req = 1'b1; a_if_addr = 32'h10; a_mem_rdata = 32'hDEADBEEF;
    check("f_idle_busy", a_busy, 0);
    tick();
    check("f_acc1_en", a_mem_en, 1);
    check("f_acc1_addr", a_mem_addr, 32'h10);
    check("f_acc1_we", a_mem_we, 0);
    check("f_acc1_gid", a_grant_id, 0);
    check("f_acc1_ack", a_if_ack, 0);
    tick();
    check("f_acc2_en", a_mem_en, 1);
    check("f_acc2_addr", a_mem_addr, 32'h10);
    check("f_acc2_ack", a_if_ack, 0);
    tick();
    check("f_resp_en", a_mem_en, 0);
    check("f_resp_ifack", a_if_ack, 1);
    check("f_resp_dmack", a_dm_ack, 0);
    check("f_rdata", a_if_rdata, 32'hDEADBEEF);
    a_if_req = 1'b0;
    tick();
    check("f_post_ack", a_if_ack, 0);
    check("f_post_busy", a_busy, 0);

    // Simultaneous requests: data write first, then fetch
    a_if_req = 1'b1; a_if_addr = 32'h44;
    a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 32'h20; a_dm_wdata = 32'h55;
    a_mem_rdata = 32'h12345678;
    tick();
    check("c_d_en", a_mem_en, 1);
    check("c_d_we", a_mem_we, 1);
    check("c_d_addr", a_mem_addr, 32'h20);
    check("c_d_wdata", a_mem_wdata, 32'h55);
    check("c_d_gid", a_grant_id, 1);
    tick();
    tick();
    check("c_d_dmack", a_dm_ack, 1);
    check("c_d_ifack", a_if_ack, 0);
    check("c_d_rdata_kept", a_dm_rdata, 0);
    a_dm_req = 1'b0; a_dm_we = 1'b0;
    tick();
    check("c_gap_busy", a_busy, 0);
    check("c_gap_en", a_mem_en, 0);
    tick();
    check("c_f_en", a_mem_en, 1);
    check("c_f_gid", a_grant_id, 0);
    check("c_f_addr", a_mem_addr, 32'h44);
    check("c_f_we", a_mem_we, 0);
    tick();
    tick();
    check("c_f_ifack", a_if_ack, 1);
    check("c_f_rdata", a_if_rdata, 32'h12345678);
    a_if_req = 1'b0;
    tick();

    // Operand changes during ACCESS are ignored; ack still issued
    a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h30; a_mem_rdata = 32'hCAFEF00D;
    tick();
    check("m_addr1", a_mem_addr, 32'h30);
    check("m_gid", a_grant_id, 1);
    a_dm_req = 1'b0; a_dm_addr = 32'h99; a_dm_we = 1'b1;
    tick();
    check("m_addr2", a_mem_addr, 32'h30);
    check("m_we2", a_mem_we, 0);
    tick();
    check("m_dmack", a_dm_ack, 1);
    check("m_rdata", a_dm_rdata, 32'hCAFEF00D);
    a_dm_we = 1'b0;
    tick();
    check("m_dmack_once", a_dm_ack, 0);
    check("m_busy", a_busy, 0);

    // Continuous data requests with fetch held
    a_if_req = 1'b1; a_if_addr = 32'h50;
    a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h60;
    for (int g = 0; g < 5; g++) begin
      tick();
      check("s_en", a_mem_en, 1);
`ifdef MEM_ARB_STARVE_GUARD_EN
      check("s_gid", a_grant_id, (g == 4) ? 1'b0 : 1'b1);
`else
      check("s_gid", a_grant_id, 1'b1);
`endif
      tick(); tick(); tick();
    end
    a_if_req = 1'b0; a_dm_req = 1'b0;
    tick();
    check("s_end_busy", a_busy, 0);

    // Asynchronous reset mid-ACCESS
    a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h70; a_mem_rdata = 32'hA5A5A5A5;
    tick();
    check("r_pre_en", a_mem_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("r_en", a_mem_en, 0);
    check("r_addr", a_mem_addr, 0);
    check("r_busy", a_busy, 0);
    check("r_gid", a_grant_id, 0);
    check("r_dm_rdata", a_dm_rdata, 0);
    check("r_if_rdata", a_if_rdata, 0);
    tick();
    check("r_hold_ack", {a_if_ack, a_dm_ack}, 0);
    tick();
    check("r_hold_busy", a_busy, 0);
    rst_n = 1'b1;
    tick();
    check("r_serve_en", a_mem_en, 1);
    check("r_serve_addr", a_mem_addr, 32'h70);
    tick();
    tick();
    check("r_serve_ack", a_dm_ack, 1);
    check("r_serve_rdata", a_dm_rdata, 32'hA5A5A5A5);
    a_dm_req = 1'b0;
    tick();
    check("r_serve_busy", a_busy, 0);

    // MEM_LAT=1 instance: fetch then data read
    b_if_req = 1'b1; b_if_addr = 32'h8; b_mem_rdata = 32'h11112222;
    tick();
    check("b_f_en", b_mem_en, 1);
    tick();
    check("b_f_ack", b_if_ack, 1);
    check("b_f_rdata", b_if_rdata, 32'h11112222);
    b_if_req = 1'b0;
    tick();
    b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 32'h80; b_mem_rdata = 32'h33334444;
    tick();
    check("b_d_en", b_mem_en, 1);
    check("b_d_addr", b_mem_addr, 32'h80);
    check("b_d_noack", b_dm_ack, 0);
    tick();
    check("b_d_ack", b_dm_ack, 1);
    check("b_d_rdata", b_dm_rdata, 32'h33334444);
    check("b_if_kept", b_if_rdata, 32'h11112222);
    b_dm_req = 1'b0;
    tick();
    check("b_busy", b_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter MEM_LAT, default 2, memory access cycles (legal range 1..15).
REQ-004 SHALL have parameter STARVE_LIMIT, default 4, consecutive fetch losses before forced fetch grant (legal range 1..15).
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-006 SHALL have the instruction-fetch port: if_req  in  1  fetch request; if_addr  in  ADDR_W  fetch address; if_rdata  out  DATA_W  fetch data; if_ack  out  1  one-cycle completion pulse.
REQ-007 SHALL have the data port: dm_req  in  1  data request; dm_we  in  1  1=write, 0=read; dm_addr  in  ADDR_W; dm_wdata  in  DATA_W; dm_rdata  out  DATA_W; dm_ack  out  1  one-cycle completion pulse.
REQ-008 SHALL have the memory port: mem_en  out  1; mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W.
REQ-009 SHALL have status outputs: busy  out  1  state!=IDLE; grant_id  out  1  0=fetch, 1=data, owner of current access.

Function
REQ-010 SHALL implement three states IDLE, ACCESS, RESP; all outputs registered or decoded from registered state only.
REQ-011 IDLE: if any req high at clock edge, SHALL select winner, latch its addr/we/wdata, set grant_id, load wait counter with MEM_LAT-1, go ACCESS; else stay IDLE.
REQ-012 Arbitration SHALL be fixed priority data over fetch (except REQ-025).
REQ-013 ACCESS: mem_en=1, mem_addr/mem_we/mem_wdata SHALL hold latched values, constant for MEM_LAT cycles; counter decrements each cycle.
REQ-014 On the last ACCESS cycle (counter==0) SHALL capture mem_rdata into the winner's rdata register (reads only) and go RESP.
REQ-015 RESP: SHALL pulse winner's ack for exactly one cycle, mem_en=0, then go IDLE unconditionally.
REQ-016 Latency from req sampled in IDLE to ack high SHALL be MEM_LAT+1 cycles; one IDLE cycle minimum between accesses.
REQ-017 if_rdata/dm_rdata SHALL hold their last captured value until the next read for that port; writes SHALL not alter dm_rdata.
REQ-018 if_ack SHALL never be asserted for a write; fetch is always a read (mem_we=0).
REQ-019 Requester SHALL hold req and operands stable until ack and drop req the cycle after ack; req deasserted mid-access SHALL NOT abort it (ack still issued).
REQ-020 Input changes to addr/wdata/we during ACCESS SHALL NOT affect the memory port.
REQ-021 if_ack and dm_ack SHALL never be high in the same cycle.

Reset
REQ-022 rst_n low SHALL immediately force state=IDLE, counter=0, starvation counter=0, all outputs 0 (mem_*, acks, rdata, busy, grant_id), regardless of clk.
REQ-023 Reset asserted mid-ACCESS or RESP SHALL drop the access with no ack; first arbitration occurs on the first rising edge after rst_n high.

Configuration
REQ-024 Macro MEM_ARB_STARVE_GUARD_EN SHALL gate the fetch starvation guard.
REQ-025 With macro defined: starvation counter increments each IDLE arbitration where if_req=1 and data wins (saturating at STARVE_LIMIT), clears on fetch grant; when counter==STARVE_LIMIT fetch SHALL win even if dm_req=1.
REQ-026 Without macro: no starvation counter logic present; strict data-over-fetch priority always.

Verification
REQ-027 Fetch only, MEM_LAT=2, if_addr=0x10, mem_rdata=0xDEADBEEF -> mem_en high 2 cycles at addr 0x10, if_ack one cycle 3 cycles after req, if_rdata=0xDEADBEEF.
REQ-028 if_req and dm_req (write, addr 0x20, wdata 0x55) same cycle -> data served first (mem_we=1, grant_id=1), dm_ack, one IDLE, then fetch served, if_ack.
REQ-029 Guard enabled, STARVE_LIMIT=4, dm_req continuously re-asserted, if_req held -> 4 data grants then fetch grant; guard disabled -> no fetch grant while dm_req high.
REQ-030 dm_req dropped and dm_addr changed during ACCESS -> mem_addr unchanged, dm_ack still pulses once.
REQ-031 rst_n pulsed low mid-ACCESS -> outputs zero asynchronously, no ack, busy=0; pending req served normally after release.
REQ-032 MEM_LAT=1 dm read -> ack 2 cycles after req, dm_rdata captured correctly, if_rdata unchanged.
